trap_sequencer: RTL and testbench

- Sequences entry to and exit from machine-mode traps for the single-issue RV64 core.
- Sits between the commit stage, the CSR unit, the AXI fetch/LSU masters and the PC generator.
- Picks one trap event per commit boundary (timer interrupt, ecall, ebreak or mret), stalls and flushes the pipeline, and waits for outstanding AXI traffic to drain.
- Then pulses a single CSR-update strobe and hands a redirect PC to fetch with a valid/ready handshake.

---
 rtl/trap_sequencer.sv | 173 +++++++++++++++++
 tb/tb_trap_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry/exit sequencer: selects one trap event per commit,
// flushes and drains the pipeline, strobes the CSR update, then redirects fetch.
module trap_sequencer #(
   parameter int unsigned XLEN      = 64,
   parameter int unsigned DRAIN_MAX = 255,
   parameter int unsigned CNT_W     = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            commit_valid,
   input  logic [XLEN-1:0] commit_pc,
   input  logic            commit_ecall,
   input  logic            commit_ebreak,
   input  logic            commit_mret,
   input  logic            mstatus_mie,
   input  logic            mie_mtie,
   input  logic            mip_mtip,
   input  logic [XLEN-1:0] mtvec,
   input  logic [XLEN-1:0] mepc,
   input  logic            fetch_busy,
   input  logic            lsu_busy,
   input  logic            redirect_ready,
   output logic            kill_commit,
   output logic            hold,
   output logic            flush,
   output logic            trap_take,
   output logic            mret_take,
   output logic [XLEN-1:0] trap_epc,
   output logic [XLEN-1:0] trap_cause,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            drain_err
);

   localparam logic [XLEN-1:0] CAUSE_MTI    = (XLEN'(1) << (XLEN - 1)) | XLEN'(7);
   localparam logic [XLEN-1:0] CAUSE_ECALL  = XLEN'(11);
   localparam logic [XLEN-1:0] CAUSE_EBREAK = XLEN'(3);
   localparam logic [XLEN-1:0] VEC_MTI_OFS  = XLEN'(4 * 7);
   localparam logic [CNT_W-1:0] CNT_LIMIT   = CNT_W'(DRAIN_MAX);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_DRAIN    = 2'd1,
      S_UPDATE   = 2'd2,
      S_REDIRECT = 2'd3
   } state_t;

   state_t            state_q,          state_d;
   logic [CNT_W-1:0]  cnt_q,            cnt_d;
   logic              is_irq_q,         is_irq_d;
   logic              is_mret_q,        is_mret_d;
   logic [XLEN-1:0]   epc_q,            epc_d;
   logic [XLEN-1:0]   cause_q,          cause_d;
   logic [XLEN-1:0]   mepc_q,           mepc_d;
   logic [XLEN-1:0]   redirect_pc_q,    redirect_pc_d;
   logic              hold_q,           hold_d;
   logic              trap_take_q,      trap_take_d;
   logic              mret_take_q,      mret_take_d;
   logic              redirect_valid_q, redirect_valid_d;
   logic              drain_err_q,      drain_err_d;

   logic              irq_c;
   logic              select_c;
   logic [XLEN-1:0]   mtvec_base_c;

   // Event qualification; selection only ever happens at an IDLE commit boundary
   always_comb begin
      irq_c        = mstatus_mie & mie_mtie & mip_mtip;
      select_c     = ~rst & (state_q == S_IDLE) & commit_valid &
                     (irq_c | commit_ecall | commit_ebreak | commit_mret);
      mtvec_base_c = {mtvec[XLEN-1:2], 2'b00};
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      is_irq_d         = is_irq_q;
      is_mret_d        = is_mret_q;
      epc_d            = epc_q;
      cause_d          = cause_q;
      mepc_d           = mepc_q;
      redirect_pc_d    = redirect_pc_q;
      drain_err_d      = drain_err_q;

      unique case (state_q)
         S_IDLE: begin
            if (select_c) begin
               state_d   = S_DRAIN;
               cnt_d     = '0;
               is_irq_d  = irq_c;
               is_mret_d = ~irq_c & ~commit_ecall & ~commit_ebreak & commit_mret;
               epc_d     = commit_pc;
               mepc_d    = mepc;
               if (irq_c)             cause_d = CAUSE_MTI;
               else if (commit_ecall) cause_d = CAUSE_ECALL;
               else if (commit_ebreak) cause_d = CAUSE_EBREAK;
               else                   cause_d = '0;
            end
         end
         S_DRAIN: begin
            // Counter runs every drain cycle; the limit forces progress on a hung bus
            cnt_d = cnt_q + CNT_W'(1);
            if (!fetch_busy && !lsu_busy) begin
               state_d = S_UPDATE;
            end else if (cnt_q == CNT_LIMIT) begin
               state_d     = S_UPDATE;
               drain_err_d = 1'b1;
            end
         end
         S_UPDATE: begin
            state_d = S_REDIRECT;
            if (is_mret_q)                              redirect_pc_d = mepc_q;
            else if (is_irq_q && mtvec[1:0] == 2'b01)   redirect_pc_d = mtvec_base_c + VEC_MTI_OFS;
            else                                        redirect_pc_d = mtvec_base_c;
         end
         S_REDIRECT: begin
            if (redirect_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      hold_d           = (state_d != S_IDLE);
      trap_take_d      = (state_d == S_UPDATE) & ~is_mret_d;
      mret_take_d      = (state_d == S_UPDATE) &  is_mret_d;
      redirect_valid_d = (state_d == S_REDIRECT);
   end

   // State and output registers, synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= S_IDLE;
         cnt_q            <= '0;
         is_irq_q         <= 1'b0;
         is_mret_q        <= 1'b0;
         epc_q            <= '0;
         cause_q          <= '0;
         mepc_q           <= '0;
         redirect_pc_q    <= '0;
         hold_q           <= 1'b0;
         trap_take_q      <= 1'b0;
         mret_take_q      <= 1'b0;
         redirect_valid_q <= 1'b0;
         drain_err_q      <= 1'b0;
      end else begin
         state_q          <= state_d;
         cnt_q            <= cnt_d;
         is_irq_q         <= is_irq_d;
         is_mret_q        <= is_mret_d;
         epc_q            <= epc_d;
         cause_q          <= cause_d;
         mepc_q           <= mepc_d;
         redirect_pc_q    <= redirect_pc_d;
         hold_q           <= hold_d;
         trap_take_q      <= trap_take_d;
         mret_take_q      <= mret_take_d;
         redirect_valid_q <= redirect_valid_d;
         drain_err_q      <= drain_err_d;
      end
   end

   assign kill_commit    = select_c & irq_c;
   assign flush          = select_c;
   assign hold           = hold_q;
   assign trap_take      = trap_take_q;
   assign mret_take      = mret_take_q;
   assign trap_epc       = epc_q;
   assign trap_cause     = cause_q;
   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;
   assign drain_err      = drain_err_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer with a per-cycle behavioural reference.
module tb_trap_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        commit_valid = 1'b0;
   logic [63:0] commit_pc = '0;
   logic        commit_ecall = 1'b0, commit_ebreak = 1'b0, commit_mret = 1'b0;
   logic        mstatus_mie = 1'b0, mie_mtie = 1'b0, mip_mtip = 1'b0;
   logic [63:0] mtvec = 64'h8000_0000;
   logic [63:0] mepc = '0;
   logic        fetch_busy = 1'b0, lsu_busy = 1'b0, redirect_ready = 1'b1;
   logic        kill_commit, hold, flush, trap_take, mret_take, redirect_valid, drain_err;
   logic [63:0] trap_epc, trap_cause, redirect_pc;

   int vectors = 0;
   int miscompares = 0;

   trap_sequencer #(.XLEN(64), .DRAIN_MAX(255), .CNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .commit_valid(commit_valid), .commit_pc(commit_pc),
      .commit_ecall(commit_ecall), .commit_ebreak(commit_ebreak), .commit_mret(commit_mret),
      .mstatus_mie(mstatus_mie), .mie_mtie(mie_mtie), .mip_mtip(mip_mtip),
      .mtvec(mtvec), .mepc(mepc),
      .fetch_busy(fetch_busy), .lsu_busy(lsu_busy), .redirect_ready(redirect_ready),
      .kill_commit(kill_commit), .hold(hold), .flush(flush),
      .trap_take(trap_take), .mret_take(mret_take),
      .trap_epc(trap_epc), .trap_cause(trap_cause),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .drain_err(drain_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: phase 0 idle, 1 draining, 2 CSR update, 3 offering redirect
   int          m_phase = 0;
   int          m_drain_cycles = 0;
   logic        m_mret = 1'b0, m_err = 1'b0;
   logic [63:0] m_epc = '0, m_cause = '0, m_tgt = '0;

   function automatic logic irq_now();
      return mstatus_mie & mie_mtie & mip_mtip;
   endfunction

   function automatic logic select_now();
      return !rst && m_phase == 0 && commit_valid &&
             (irq_now() || commit_ecall || commit_ebreak || commit_mret);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_phase = 0; m_err = 1'b0; m_mret = 1'b0;
         m_epc = '0; m_cause = '0; m_tgt = '0;
      end else begin
         case (m_phase)
            0: if (select_now()) begin
               m_epc  = commit_pc;
               m_mret = !irq_now() && !commit_ecall && !commit_ebreak;
               if (irq_now()) begin
                  m_cause = 64'h8000_0000_0000_0007;
                  m_tgt   = (mtvec & ~64'h3) + ((mtvec[1:0] == 2'b01) ? 64'd28 : 64'd0);
               end else begin
                  m_cause = commit_ecall ? 64'd11 : (commit_ebreak ? 64'd3 : 64'd0);
                  m_tgt   = m_mret ? mepc : (mtvec & ~64'h3);
               end
               m_drain_cycles = 0;
               m_phase = 1;
            end
            1: begin
               m_drain_cycles++;
               if (!fetch_busy && !lsu_busy) m_phase = 2;
               else if (m_drain_cycles == 256) begin m_err = 1'b1; m_phase = 2; end
            end
            2: m_phase = 3;
            3: if (redirect_ready) m_phase = 0;
            default: m_phase = 0;
         endcase
      end
   end

   // Every-cycle comparison against the reference
   always @(negedge clk) begin
      chk("m_kill",   kill_commit,    select_now() && irq_now());
      chk("m_flush",  flush,          select_now());
      chk("m_hold",   hold,           m_phase != 0);
      chk("m_trap",   trap_take,      m_phase == 2 && !m_mret);
      chk("m_mret",   mret_take,      m_phase == 2 &&  m_mret);
      chk("m_rvalid", redirect_valid, m_phase == 3);
      chk("m_derr",   drain_err,      m_err);
      if (m_phase == 2 && !m_mret) begin
         chk("m_epc",   trap_epc,   m_epc);
         chk("m_cause", trap_cause, m_cause);
      end
      if (m_phase == 3) chk("m_rpc", redirect_pc, m_tgt);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_hold"},   hold, 0);
      chk({nm, "_trap"},   trap_take, 0);
      chk({nm, "_mret"},   mret_take, 0);
      chk({nm, "_rvalid"}, redirect_valid, 0);
      chk({nm, "_rpc"},    redirect_pc, 0);
      chk({nm, "_epc"},    trap_epc, 0);
      chk({nm, "_cause"},  trap_cause, 0);
      chk({nm, "_derr"},   drain_err, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      cyc(); cyc();
      rst = 1'b0;
      #2; chk_all_zero("reset");

      // ecall, direct mtvec, no backpressure
      cyc(); commit_valid = 1; commit_ecall = 1; commit_pc = 64'h8000_0100; #2;
      chk("ec_flush", flush, 1); chk("ec_kill", kill_commit, 0);
      cyc(); commit_valid = 0; commit_ecall = 0; #2;
      chk("ec_hold", hold, 1); chk("ec_notrap_t1", trap_take, 0);
      cyc(); #2;
      chk("ec_trap", trap_take, 1); chk("ec_epc", trap_epc, 64'h8000_0100); chk("ec_cause", trap_cause, 64'd11);
      cyc(); #2;
      chk("ec_rvalid", redirect_valid, 1); chk("ec_rpc", redirect_pc, 64'h8000_0000);
      cyc(); #2;
      chk("ec_idle_hold", hold, 0); chk("ec_idle_rvalid", redirect_valid, 0);

      // timer interrupt with vectored mtvec beats a simultaneous ecall
      cyc(); mtvec = 64'h8000_0001; mstatus_mie = 1; mie_mtie = 1; mip_mtip = 1;
      commit_valid = 1; commit_ecall = 1; commit_pc = 64'h8000_0200; #2;
      chk("irq_kill", kill_commit, 1); chk("irq_flush", flush, 1);
      cyc(); commit_valid = 0; commit_ecall = 0; mip_mtip = 0; #2;
      cyc(); #2;
      chk("irq_trap", trap_take, 1); chk("irq_cause", trap_cause, 64'h8000_0000_0000_0007);
      chk("irq_epc", trap_epc, 64'h8000_0200);
      cyc(); #2;
      chk("irq_rpc", redirect_pc, 64'h8000_001C);
      cyc(); mtvec = 64'h8000_0000; mstatus_mie = 0; mie_mtie = 0;

      // mret with LSU busy for five cycles; mepc latched at selection
      cyc(); mepc = 64'h8000_0204; commit_valid = 1; commit_mret = 1; lsu_busy = 1; #2;
      chk("mr_kill", kill_commit, 0);
      for (int k = 1; k <= 4; k++) begin
         cyc(); commit_valid = 0; commit_mret = 0; mepc = '0; #2;
         chk("mr_hold", hold, 1); chk("mr_early", mret_take, 0);
      end
      cyc(); lsu_busy = 0; #2;
      chk("mr_hold5", hold, 1); chk("mr_early5", mret_take, 0);
      cyc(); #2;
      chk("mr_take", mret_take, 1); chk("mr_notrap", trap_take, 0);
      cyc(); #2;
      chk("mr_rpc", redirect_pc, 64'h8000_0204); chk("mr_once", mret_take, 0);
      cyc();

      // fetch_busy stuck: DRAIN times out after DRAIN_MAX+1 cycles
      cyc(); commit_valid = 1; commit_ebreak = 1; commit_pc = 64'h8000_0400; fetch_busy = 1;
      cyc(); commit_valid = 0; commit_ebreak = 0;
      n = 0;
      for (int k = 1; k <= 400; k++) begin
         #2;
         if (trap_take === 1'b1) begin n = k; break; end
         cyc();
      end
      chk("to_latency", n, 257);
      chk("to_derr", drain_err, 1); chk("to_cause", trap_cause, 64'd3);
      chk("to_epc", trap_epc, 64'h8000_0400);
      cyc(); fetch_busy = 0; #2;
      chk("to_rpc", redirect_pc, 64'h8000_0000);
      cyc(); #2; chk("to_idle", hold, 0);

      // redirect backpressure for four cycles
      cyc(); redirect_ready = 0; commit_valid = 1; commit_ecall = 1; commit_pc = 64'h8000_0300;
      cyc(); commit_valid = 0; commit_ecall = 0;
      cyc();
      for (int k = 0; k < 4; k++) begin
         cyc(); #2;
         chk("bp_rvalid", redirect_valid, 1); chk("bp_rpc", redirect_pc, 64'h8000_0000);
      end
      cyc(); redirect_ready = 1; #2;
      chk("bp_rvalid_hs", redirect_valid, 1);
      cyc(); #2;
      chk("bp_idle", hold, 0); chk("bp_derr_sticky", drain_err, 1);

      // reset during UPDATE
      cyc(); commit_valid = 1; commit_ecall = 1; commit_pc = 64'h8000_0500;
      cyc(); commit_valid = 0; commit_ecall = 0;
      cyc(); rst = 1; #2; chk("ru_trap", trap_take, 1);
      cyc(); rst = 0; #2; chk_all_zero("ru");
      cyc(); #2; chk("ru_nostrobe", trap_take, 0); chk("ru_norv", redirect_valid, 0);

      // reset during REDIRECT
      cyc(); commit_valid = 1; commit_ecall = 1; commit_pc = 64'h8000_0580;
      cyc(); commit_valid = 0; commit_ecall = 0;
      cyc();
      cyc(); redirect_ready = 0; rst = 1; #2; chk("rr_rvalid", redirect_valid, 1);
      cyc(); rst = 0; redirect_ready = 1; #2; chk_all_zero("rr");
      cyc(); #2; chk("rr_norv", redirect_valid, 0);

      // normal ecall after reset
      cyc(); commit_valid = 1; commit_ecall = 1; commit_pc = 64'h8000_0600; #2;
      chk("pr_flush", flush, 1);
      cyc(); commit_valid = 0; commit_ecall = 0;
      cyc(); #2;
      chk("pr_trap", trap_take, 1); chk("pr_epc", trap_epc, 64'h8000_0600);
      cyc(); #2; chk("pr_rpc", redirect_pc, 64'h8000_0000);
      cyc(); cyc();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
